stage1_schedule: RTL and testbench

STAGE1_SCHEDULE -- requirements
Module: stage1_schedule

---
 rtl/sha256_pkg.sv | 23 ++
 rtl/sched_sigma_func.sv | 15 +
 rtl/stage1_schedule.sv | 91 +++++++++
 tb/tb_stage1_schedule.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and round constants, used by the schedule stage and the round stage.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sched_sigma_func.sv
// Message-schedule small sigma: SEL=0 gives s0 (ROTR7^ROTR18^SHR3), SEL=1 gives s1 (ROTR17^ROTR19^SHR10).
module sched_sigma_func #(
  parameter bit SEL = 1'b0
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  if (SEL == 1'b0) begin : g_s0
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  end else begin : g_s1
    assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  end

endmodule

// File: rtl/stage1_schedule.sv
// SHA-256 message schedule: loads 16 words, then issues W[t]+K[t] for t=0..63 over a valid/ready link.
module stage1_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        wk_valid,
  input  logic        wk_ready,
  output logic [31:0] wk_word,
  output logic [5:0]  round_idx,
  output logic        wk_last,
  output logic        busy
);

  sched_state_e state, state_nxt;
  logic [3:0]   ld_cnt;
  logic [5:0]   t;
  word_t        w [16];
  word_t        s0_w1, s1_w14, w_new;
  logic         accept, advance, load_done;

  sched_sigma_func #(.SEL(1'b0)) u_s0 (.x(w[1]),  .y(s0_w1));
  sched_sigma_func #(.SEL(1'b1)) u_s1 (.x(w[14]), .y(s1_w14));

  assign w_new     = s1_w14 + w[9] + s0_w1 + w[0];
  assign in_ready  = (state == LOAD);
  assign accept    = in_valid & in_ready;
  assign load_done = accept & (ld_cnt == 4'd15);
  // A slot opens whenever the output register is empty or being consumed.
  assign advance   = (state == RUN) & (~wk_valid | wk_ready);
  assign busy      = ~((state == LOAD) & (ld_cnt == 4'd0));
  assign wk_last   = wk_valid & (round_idx == 6'd63);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_done)              state_nxt = RUN;
      RUN:     if (advance && t == 6'd63)  state_nxt = DRAIN;
      DRAIN:   if (wk_ready)               state_nxt = LOAD;
      default:                             state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= 4'd0;
      t      <= 6'd0;
    end else begin
      if (load_done)   ld_cnt <= 4'd0;
      else if (accept) ld_cnt <= ld_cnt + 4'd1;
      if (load_done)                   t <= 6'd0;
      else if (advance && t != 6'd63)  t <= t + 6'd1;
    end
  end

  // Stage boundary: 16-word sliding window, expanded one word per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (accept) begin
      w[ld_cnt] <= in_word;
    end else if (advance) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end

  // Stage boundary: registered W[t]+K[t] output toward the round stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wk_valid  <= 1'b0;
      wk_word   <= '0;
      round_idx <= '0;
    end else if (advance) begin
      wk_valid  <= 1'b1;
      wk_word   <= w[0] + K[t];
      round_idx <= t;
    end else if (state == DRAIN && wk_ready) begin
      wk_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage1_schedule.sv
// Scoreboard bench for stage1_schedule: reference schedule expansion vs. DUT output stream.
module tb_stage1_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, wk_valid, wk_last, busy;
  logic        wk_ready;
  logic [31:0] wk_word;
  logic [5:0]  round_idx;

  stage1_schedule dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .wk_valid(wk_valid), .wk_ready(wk_ready), .wk_word(wk_word), .round_idx(round_idx),
    .wk_last(wk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct { int idx; logic [31:0] w; } exp_t;
  exp_t        exp_q [$];
  exp_t        e;
  logic [31:0] cur_blk [16];
  logic [31:0] out_log [64];
  int          checks = 0;
  int          errors = 0;
  bit          blk_done = 1'b0;
  bit          bp_en = 1'b0;
  logic        bp_rand = 1'b1;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_word;
  logic [5:0]  prev_idx;

  assign wk_ready = bp_en ? bp_rand : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // FIPS 180-4 schedule expansion W[0..63]; expectation is W[t]+K[t].
  task automatic push_expected();
    logic [31:0] ws [64];
    logic [31:0] ss0, ss1;
    exp_t x;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) ws[i] = cur_blk[i];
      else begin
        ss0 = rotr(ws[i-15], 7) ^ rotr(ws[i-15], 18) ^ (ws[i-15] >> 3);
        ss1 = rotr(ws[i-2], 17) ^ rotr(ws[i-2], 19) ^ (ws[i-2] >> 10);
        ws[i] = ss1 + ws[i-7] + ss0 + ws[i-16];
      end
      x.idx = i;
      x.w   = ws[i] + KT[i];
      exp_q.push_back(x);
    end
  endtask

  always @(posedge clk) begin
    #1;
    bp_rand = 1'($urandom_range(0, 1));
  end

  // Monitor: sampled on the falling edge, midway between active edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(wk_valid), 32'd1);
        chk("hold_word", wk_word, prev_word);
        chk("hold_idx", 32'(round_idx), 32'(prev_idx));
      end
      if (wk_valid) begin
        chk("wk_last", 32'(wk_last), 32'(round_idx == 6'd63));
        if (wk_ready) begin
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got idx %0d word %h, expected no output", round_idx, wk_word);
          end else begin
            e = exp_q.pop_front();
            chk("round_idx", 32'(round_idx), 32'(e.idx));
            chk("wk_word", wk_word, e.w);
            out_log[round_idx] = wk_word;
            if (round_idx == 6'd63) blk_done = 1'b1;
          end
        end else begin
          stall_prev = 1'b1;
          prev_word  = wk_word;
          prev_idx   = round_idx;
        end
      end else begin
        stall_prev = 1'b0;
        chk("wk_last_idle", 32'(wk_last), 32'd0);
      end
    end
  end

  task automatic load_block(input bit gap);
    bit acc;
    blk_done = 1'b0;
    push_expected();
    for (int i = 0; i < 16; i++) begin
      if (gap && i == 8) begin
        in_valid = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          chk("busy_gap", 32'(busy), 32'd1);
        end
      end
      in_valid = 1'b1;
      in_word  = cur_blk[i];
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
        @(negedge clk);
        if (in_ready) acc = 1'b1;
        @(posedge clk); #1;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: word %0d not accepted, required acceptance", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_block(input bit junk);
    int c;
    for (c = 0; c < 3000 && !blk_done; c++) begin
      @(posedge clk); #1;
      if (junk) begin
        in_valid = 1'b1;
        in_word  = $urandom;
        if (wk_valid) chk("in_ready_run", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    if (!blk_done) begin
      checks++;
      errors++;
      $display("FAIL block_timeout: last output not seen, required round 63");
    end
    chk("busy_idle", 32'(busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_blk[i] = '0;
    cur_blk[0]  = 32'h61626380;
    cur_blk[15] = 32'h00000018;
  endtask

  initial begin
    bit found;
    // Reset state
    #3;
    chk("rst_wk_valid", 32'(wk_valid), 32'd0);
    chk("rst_wk_word", wk_word, 32'd0);
    chk("rst_round_idx", 32'(round_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // "abc" block, no backpressure
    set_abc();
    load_block(1'b0);
    wait_block(1'b0);
    chk("abc_t0", out_log[0], 32'hA3EC9318);
    chk("abc_t15", out_log[15], 32'hC19BF18C);
    chk("abc_t16", out_log[16], 32'h45FDCD41);

    // "abc" block under random backpressure
    bp_en = 1'b1;
    load_block(1'b0);
    wait_block(1'b0);

    // in_valid held high with changing words during RUN/DRAIN
    load_block(1'b0);
    wait_block(1'b1);
    chk("junk_t16", out_log[16], 32'h45FDCD41);

    // Reset in the middle of issuing
    bp_en = 1'b0;
    load_block(1'b0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #2;
      if (wk_valid && round_idx == 6'd30) found = 1'b1;
    end
    chk("reached_idx30", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wk_valid", 32'(wk_valid), 32'd0);
    chk("midrst_wk_word", wk_word, 32'd0);
    chk("midrst_round_idx", 32'(round_idx), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_log[0] = '0;
    load_block(1'b0);
    wait_block(1'b0);
    chk("reload_t0", out_log[0], 32'hA3EC9318);

    // Back-to-back: all-zero block then "abc", with backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 16; i++) cur_blk[i] = '0;
    load_block(1'b0);
    wait_block(1'b0);
    for (int i = 0; i < 16; i++) chk("zero_blk_k", out_log[i], KT[i]);
    set_abc();
    load_block(1'b0);
    wait_block(1'b0);
    chk("b2b_abc_t0", out_log[0], 32'hA3EC9318);
    chk("b2b_abc_t16", out_log[16], 32'h45FDCD41);

    // Random blocks, one loaded with a 10-cycle gap after word 8
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
      load_block(b == 1);
      wait_block(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
